// File: rtl/hilo_unit.sv
// HI/LO register pair and multiply/divide sequencer: gates the multiplier and
// divider controls, captures their results, and handles mthi/mtlo and aborts.
module hilo_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] regB_out,
  input  logic        finalMult,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        finalDiv,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] write_data,
  output logic        multControl,
  output logic        divControl,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            mult_ctl_q;
  logic            div_ctl_q;
  logic            busy_q;
  logic            done_q;
  logic            div_zero_q;
  logic            timeout_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;

  logic            fin_s;
  logic [31:0]     src_hi_s;
  logic [31:0]     src_lo_s;
  logic            capture_s;
  logic            watchdog_s;

  // Route the completion level and result pair of whichever unit is running.
  always_comb begin
    fin_s    = 1'b0;
    src_hi_s = mult_hi;
    src_lo_s = mult_lo;
    case (state_q)
      MULT_RUN: begin
        fin_s    = finalMult;
        src_hi_s = mult_hi;
        src_lo_s = mult_lo;
      end
      DIV_RUN: begin
        fin_s    = finalDiv;
        src_hi_s = div_hi;
        src_lo_s = div_lo;
      end
      default: begin
        fin_s    = 1'b0;
        src_hi_s = mult_hi;
        src_lo_s = mult_lo;
      end
    endcase
  end

  // First RUN cycle ignores completion: the multiplier is still clearing a stale finalMult.
  assign capture_s  = fin_s && (cnt_q != {CW{1'b0}});
  assign watchdog_s = (cnt_q == CW'(TIMEOUT - 1));

  // Sequencer FSM with registered control, status pulses and HI/LO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      mult_ctl_q <= 1'b0;
      div_ctl_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      timeout_q  <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= {CW{1'b0}};
          if (hi_write) hi_q <= write_data;
          if (lo_write) lo_q <= write_data;
          if (mult_start) begin
            state_q    <= MULT_RUN;
            mult_ctl_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (div_start) begin
            if (regB_out != 32'd0) begin
              state_q   <= DIV_RUN;
              div_ctl_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              div_zero_q <= 1'b1;
            end
          end
        end
        MULT_RUN, DIV_RUN: begin
          if (capture_s || watchdog_s) begin
            state_q    <= IDLE;
            mult_ctl_q <= 1'b0;
            div_ctl_q  <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            if (capture_s) begin
              hi_q   <= src_hi_s;
              lo_q   <= src_lo_s;
              done_q <= 1'b1;
            end else begin
              timeout_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          mult_ctl_q <= 1'b0;
          div_ctl_q  <= 1'b0;
          busy_q     <= 1'b0;
          cnt_q      <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign multControl = mult_ctl_q;
  assign divControl  = div_ctl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_zero    = div_zero_q;
  assign timeout     = timeout_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: behavioural multiplier/divider models plus per-scenario
// tasks comparing HI/LO, latency and status pulses against arithmetic references.
module tb_hilo_unit;

  localparam int TO = 64;

  logic        clock, reset;
  logic        mult_start, div_start, hi_write, lo_write;
  logic [31:0] regB_out, write_data;
  logic        finalMult, finalDiv;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        multControl, divControl, busy, done, div_zero, timeout;
  logic [31:0] hi_out, lo_out;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_hi, exp_lo;

  logic        mult_dead, div_dead;
  int          mcnt, dcnt, div_lat;
  logic [31:0] ma, mb, da, db;

  hilo_unit #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .mult_start(mult_start), .div_start(div_start), .regB_out(regB_out),
    .finalMult(finalMult), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .finalDiv(finalDiv), .div_hi(div_hi), .div_lo(div_lo),
    .hi_write(hi_write), .lo_write(lo_write), .write_data(write_data),
    .multControl(multControl), .divControl(divControl),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .div_zero(div_zero), .timeout(timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Multiplier/divider models: init on the edge after control rises, result a fixed count later.
  always @(negedge clock) begin
    if (reset) begin
      mcnt = 0; dcnt = 0;
      finalMult = 1'b0; finalDiv = 1'b0;
      mult_hi = 32'd0; mult_lo = 32'd0; div_hi = 32'd0; div_lo = 32'd0;
    end else begin
      if (multControl) begin
        mcnt++;
        if (mcnt == 2) begin
          finalMult = 1'b0;
          mult_hi = $urandom; mult_lo = $urandom;
        end
        if (mcnt == 35 && !mult_dead) begin
          {mult_hi, mult_lo} = longint'(int'(ma)) * longint'(int'(mb));
          finalMult = 1'b1;
        end
      end else begin
        mcnt = 0;
      end
      if (divControl) begin
        dcnt++;
        if (dcnt == 2) begin
          finalDiv = 1'b0;
          div_hi = $urandom; div_lo = $urandom;
        end
        if (dcnt == div_lat && !div_dead) begin
          div_lo = int'(da) / int'(db);
          div_hi = int'(da) % int'(db);
          finalDiv = 1'b1;
        end
      end else begin
        dcnt = 0;
      end
    end
  end

  task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ma = a; mb = b; mult_start = 1'b1;
    @(posedge clock); #1;
    mult_start = 1'b0;
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    da = a; db = b; regB_out = b; div_start = 1'b1;
    @(posedge clock); #1;
    div_start = 1'b0;
  endtask

  task automatic do_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clock);
    hi_write = h; lo_write = l; write_data = d;
    @(posedge clock); #1;
    hi_write = 1'b0; lo_write = 1'b0;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
  endtask

  // Edges counted from the accepting edge until done or timeout is seen; -1 if neither.
  task automatic wait_event(output int k);
    k = -1;
    for (int i = 1; i <= TO + 10; i++) begin
      @(posedge clock); #1;
      if (done || timeout) begin
        k = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vecs++;
    if ({multControl, divControl, busy, done, div_zero, timeout, hi_out, lo_out} !== 70'd0)
      $display("FAIL reset_state: got %h want 0",
               {multControl, divControl, busy, done, div_zero, timeout, hi_out, lo_out});
    @(negedge clock);
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic test_mult(input logic [31:0] a, input logic [31:0] b);
    int k;
    logic [63:0] p;
    p = longint'(int'(a)) * longint'(int'(b));
    start_mult(a, b);
    vecs++;
    if (busy !== 1'b1 || multControl !== 1'b1 || divControl !== 1'b0) begin
      errs++;
      $display("FAIL mult_start_ctl: busy=%b mc=%b dc=%b want 1 1 0", busy, multControl, divControl);
    end
    wait_event(k);
    vecs++;
    if (k !== 35 || done !== 1'b1) begin
      errs++;
      $display("FAIL mult_latency: got %0d done=%b want 35 done=1", k, done);
    end
    exp_hi = p[63:32]; exp_lo = p[31:0];
    vecs++;
    if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      errs++;
      $display("FAIL mult_result %h*%h: got %h_%h want %h_%h", a, b, hi_out, lo_out, exp_hi, exp_lo);
    end
    vecs++;
    if (multControl !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL mult_ctl_drop: mc=%b busy=%b want 0 0", multControl, busy);
    end
    repeat (3) @(posedge clock);
    #1;
    vecs++;
    if (multControl !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL mult_no_rerun: mc=%b busy=%b done=%b want 0 0 0", multControl, busy, done);
    end
  endtask

  task automatic test_div(input logic [31:0] a, input logic [31:0] b, input int lat);
    int k;
    div_lat = lat;
    start_div(a, b);
    vecs++;
    if (busy !== 1'b1 || divControl !== 1'b1 || multControl !== 1'b0) begin
      errs++;
      $display("FAIL div_start_ctl: busy=%b dc=%b mc=%b want 1 1 0", busy, divControl, multControl);
    end
    wait_event(k);
    vecs++;
    if (k !== lat || done !== 1'b1) begin
      errs++;
      $display("FAIL div_latency: got %0d done=%b want %0d done=1", k, done, lat);
    end
    exp_lo = int'(a) / int'(b);
    exp_hi = int'(a) % int'(b);
    vecs++;
    if (hi_out !== exp_hi || lo_out !== exp_lo || divControl !== 1'b0) begin
      errs++;
      $display("FAIL div_result %h/%h: got r=%h q=%h dc=%b want r=%h q=%h dc=0",
               a, b, hi_out, lo_out, divControl, exp_hi, exp_lo);
    end
  endtask

  task automatic test_div_zero;
    do_write(1'b1, 1'b0, 32'h12345678);
    do_write(1'b0, 1'b1, 32'h9ABCDEF0);
    start_div(32'd100, 32'd0);
    vecs++;
    if (div_zero !== 1'b1 || divControl !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL div_zero_pulse: dz=%b dc=%b busy=%b want 1 0 0", div_zero, divControl, busy);
    end
    @(posedge clock); #1;
    vecs++;
    if (div_zero !== 1'b0 || divControl !== 1'b0 || hi_out !== exp_hi || lo_out !== exp_lo) begin
      errs++;
      $display("FAIL div_zero_hold: dz=%b dc=%b hi=%h lo=%h want 0 0 %h %h",
               div_zero, divControl, hi_out, lo_out, exp_hi, exp_lo);
    end
  endtask

  task automatic test_stale_and_timeout;
    int k;
    // The previous mult leaves finalMult high; the new run must not capture on its first cycle.
    test_mult(32'hFFFFFF00, 32'h00000123);
    mult_dead = 1'b1;
    start_mult(32'd9, 32'd9);
    wait_event(k);
    vecs++;
    if (k !== TO || timeout !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL mult_timeout: got k=%0d to=%b done=%b want %0d 1 0", k, timeout, done, TO);
    end
    vecs++;
    if (hi_out !== exp_hi || lo_out !== exp_lo || multControl !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL timeout_hold: hi=%h lo=%h mc=%b busy=%b want %h %h 0 0",
               hi_out, lo_out, multControl, busy, exp_hi, exp_lo);
    end
    @(posedge clock); #1;
    vecs++;
    if (timeout !== 1'b0) begin
      errs++;
      $display("FAIL timeout_pulse: got %b want 0", timeout);
    end
    mult_dead = 1'b0;
    div_dead = 1'b1;
    div_lat = 5;
    start_div(32'd50, 32'd7);
    wait_event(k);
    vecs++;
    if (k !== TO || timeout !== 1'b1 || hi_out !== exp_hi || lo_out !== exp_lo) begin
      errs++;
      $display("FAIL div_timeout: got k=%0d to=%b hi=%h lo=%h want %0d 1 %h %h",
               k, timeout, hi_out, lo_out, TO, exp_hi, exp_lo);
    end
    div_dead = 1'b0;
  endtask

  task automatic test_priority_and_ignore;
    int k;
    logic [63:0] p;
    // Runs right after a div, so a stale finalDiv stays high through MULT_RUN.
    p = longint'(int'(32'h00012345)) * longint'(int'(32'hFFFF0001));
    @(negedge clock);
    ma = 32'h00012345; mb = 32'hFFFF0001; da = 32'd10; db = 32'd3; regB_out = 32'd3;
    mult_start = 1'b1; div_start = 1'b1;
    @(posedge clock); #1;
    mult_start = 1'b0; div_start = 1'b0;
    vecs++;
    if (multControl !== 1'b1 || divControl !== 1'b0) begin
      errs++;
      $display("FAIL start_priority: mc=%b dc=%b want 1 0", multControl, divControl);
    end
    k = -1;
    for (int i = 1; i <= TO + 10; i++) begin
      @(posedge clock); #1;
      if (i == 5) begin
        div_start = 1'b1; mult_start = 1'b1; hi_write = 1'b1; lo_write = 1'b1;
        write_data = 32'hDEADBEEF;
      end
      if (i == 6) begin
        div_start = 1'b0; mult_start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
      end
      if (done || timeout) begin
        k = i;
        break;
      end
    end
    exp_hi = p[63:32]; exp_lo = p[31:0];
    vecs++;
    if (k !== 35 || hi_out !== exp_hi || lo_out !== exp_lo || divControl !== 1'b0) begin
      errs++;
      $display("FAIL busy_ignore: k=%0d hi=%h lo=%h dc=%b want 35 %h %h 0",
               k, hi_out, lo_out, divControl, exp_hi, exp_lo);
    end
    repeat (2) @(posedge clock);
    #1;
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL no_queued_start: busy=%b want 0", busy);
    end
    do_write(1'b1, 1'b0, 32'hCAFEF00D);
    vecs++;
    if (hi_out !== 32'hCAFEF00D || lo_out !== exp_lo) begin
      errs++;
      $display("FAIL mthi: hi=%h lo=%h want cafef00d %h", hi_out, lo_out, exp_lo);
    end
  endtask

  task automatic test_reset_mid_op;
    start_mult(32'h00000101, 32'h00000202);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if ({multControl, divControl, busy, done, div_zero, timeout, hi_out, lo_out} !== 70'd0) begin
      errs++;
      $display("FAIL async_reset: got %h want 0",
               {multControl, divControl, busy, done, div_zero, timeout, hi_out, lo_out});
    end
    @(negedge clock);
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    test_mult(32'd2, 32'd3);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int n = 0; n < 6; n++) begin
      a = $urandom; b = $urandom;
      test_mult(a, b);
    end
    for (int n = 0; n < 6; n++) begin
      a = $urandom;
      b = $urandom_range(1, 1000);
      if ($urandom_range(0, 1) == 1) b = -b;
      test_div(a, b, $urandom_range(2, 40));
    end
  endtask

  initial begin
    mult_start = 1'b0; div_start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    regB_out = 32'd0; write_data = 32'd0;
    mult_dead = 1'b0; div_dead = 1'b0; div_lat = 10;
    ma = 32'd0; mb = 32'd0; da = 32'd0; db = 32'd1;
    test_reset;
    test_mult(32'h00000007, 32'hFFFFFFFD);
    test_div(32'd17, 32'd5, 12);
    test_div_zero;
    test_stale_and_timeout;
    test_div(32'hFFFFFF9C, 32'd7, 20);
    test_priority_and_ignore;
    test_reset_mid_op;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
